// File: rtl/prbs_bert_pkg.sv
// Shared definitions for the PRBS31 bit-error-rate tester.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: FSM state encoding, generator seed, feedback taps, error window length,
// and the feedback helper used by both the generator and the checker.
package prbs_bert_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_CHECK = 3'd2
  } bert_state_t;

  localparam logic [30:0] SEED    = 31'd1;
  localparam int          TAP_A   = 30;
  localparam int          TAP_B   = 27;
  localparam int          WIN_LEN = 32;

  // x^31 + x^28 + 1 feedback: next bit of the sequence from the current 31-bit history.
  function automatic logic prbs_fb(input logic [30:0] v);
    return v[TAP_A] ^ v[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_lfsr.sv
// PRBS31 generator LFSR (x^31 + x^28 + 1), shift-left Fibonacci form.
// Latency: q updates on the rising edge after load/adv.
// Backpressure: none; the register holds whenever neither load nor adv is high.
// Ports: clk, rst_n (async, active-low) | load (reseed, wins over adv), adv (step one bit) | q[30:0] state.
module prbs31_lfsr
  import prbs_bert_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [30:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (adv) begin
      q <= {q[29:0], prbs_fb(q)};
    end
  end

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 bit-error-rate tester: generator, self-synchronising checker, lock and loss detection.
// Latency: err_cnt and locked update one cycle after the checked bit; tx_bit is registered.
// Backpressure: none; ena=0 freezes every register and masks start/stop.
// Ports: clk, rst_n (async, active-low) | ena, start, stop, inject | rx_bit in, tx_bit out |
//        locked, err_cnt[ERR_W-1:0], state[2:0] (0 IDLE, 1 SYNC, 2 CHECK).
// Build option: define PRBS_ERR_INJECT_EN to enable single-bit error injection on tx_bit.
module prbs31_bert_ctrl
  import prbs_bert_pkg::*;
#(
  parameter int LOCK_BITS = 64,
  parameter int LOSS_THR  = 4,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic             inject,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       state
);

  localparam int          RUN_W    = $clog2(LOCK_BITS + 1);
  localparam int          WERR_W   = $clog2(LOSS_THR + 1);
  localparam int          WPOS_W   = $clog2(WIN_LEN);
  localparam logic [4:0]  SYNC_END = 5'd30;  // last of the 31 seeding cycles

  bert_state_t       state_q, state_nxt;
  logic [30:0]       gen_q;
  logic [30:0]       chk;
  logic [4:0]        sync_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [WPOS_W-1:0] win_pos;
  logic [WERR_W-1:0] win_err;

  logic        cmd_stop, cmd_start;
  logic [30:0] chk_shift;
  logic        expected, bit_err, sync_done, sync_zero, loss;

  // stop beats start; both are only honoured on enabled cycles
  assign cmd_stop  = ena & stop;
  assign cmd_start = ena & start & ~stop;

  assign chk_shift = {chk[29:0], rx_bit};
  assign expected  = prbs_fb(chk);
  assign bit_err   = (state_q == ST_CHECK) && (rx_bit != expected);
  assign sync_done = (state_q == ST_SYNC) && (sync_cnt == SYNC_END);
  // an all-zero history is the LFSR lock-up state and cannot predict anything
  assign sync_zero = (chk_shift == 31'd0);
  assign loss      = bit_err && (win_err == WERR_W'(LOSS_THR - 1));

  prbs31_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cmd_start),
    .adv   (ena && (state_q != ST_IDLE)),
    .q     (gen_q)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (cmd_stop) begin
      state_nxt = ST_IDLE;
    end else if (cmd_start) begin
      state_nxt = ST_SYNC;
    end else if (ena) begin
      case (state_q)
        ST_SYNC:  if (sync_done && !sync_zero) state_nxt = ST_CHECK;
        ST_CHECK: if (loss) state_nxt = ST_SYNC;
        default:  state_nxt = state_q;
      endcase
    end
  end

  assign state = state_q;

  // ---------------- checker datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk      <= '0;
      sync_cnt <= '0;
      run_cnt  <= '0;
      win_pos  <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else if (cmd_stop) begin
      locked <= 1'b0;
    end else if (cmd_start) begin
      sync_cnt <= '0;
      run_cnt  <= '0;
      win_pos  <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else if (ena) begin
      case (state_q)
        ST_SYNC: begin
          chk      <= chk_shift;
          sync_cnt <= sync_done ? 5'd0 : sync_cnt + 5'd1;
        end
        ST_CHECK: begin
          // the checker free-runs on its own prediction so one bad bit costs one error
          chk <= {chk[29:0], expected};
          if (bit_err) begin
            run_cnt <= '0;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          end else begin
            if (run_cnt != RUN_W'(LOCK_BITS)) run_cnt <= run_cnt + RUN_W'(1);
            if (run_cnt == RUN_W'(LOCK_BITS - 1)) locked <= 1'b1;
          end
          if (loss) begin
            locked   <= 1'b0;
            win_pos  <= '0;
            win_err  <= '0;
            sync_cnt <= '0;
          end else begin
            if (win_pos == WPOS_W'(WIN_LEN - 1)) begin
              win_pos <= '0;
              win_err <= '0;
            end else begin
              win_pos <= win_pos + WPOS_W'(1);
              if (bit_err) win_err <= win_err + WERR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- transmit path ----------------
`ifdef PRBS_ERR_INJECT_EN
  logic inj_q;

  // one-shot inversion; the generator itself never sees the injected error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q <= 1'b0;
    end else if (ena) begin
      inj_q <= inject && (state_q != ST_IDLE);
    end
  end

  assign tx_bit = gen_q[TAP_A] ^ inj_q;
`else
  logic unused_inject;
  assign unused_inject = inject;
  assign tx_bit        = gen_q[TAP_A];
`endif

endmodule

// File: doc/prbs31_bert_ctrl.md
PRBS31_BERT_CTRL -- requirements
Module: prbs31_bert_ctrl

Interface
REQ-001 SHALL have parameter LOCK_BITS, default 64: consecutive error-free checked bits required to assert locked.
REQ-002 SHALL have parameter LOSS_THR, default 4: errors within one 32-bit window that force resynchronisation.
REQ-003 SHALL have parameter ERR_W, default 16: width of err_cnt.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ena, input, 1: clock enable; when low, all state holds.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that starts or restarts a test.
REQ-008 SHALL have port stop, input, 1: single-cycle pulse that returns the block to IDLE.
REQ-009 SHALL have port inject, input, 1: single-cycle error-injection request; ignored unless PRBS_ERR_INJECT_EN is defined.
REQ-010 SHALL have port rx_bit, input, 1: received (looped-back) serial bit.
REQ-011 SHALL have port tx_bit, output, 1: generated PRBS31 bit.
REQ-012 SHALL have port locked, output, 1: checker lock indication.
REQ-013 SHALL have port err_cnt, output, ERR_W: saturating cumulative bit-error count.
REQ-014 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-015 SHALL implement the generator as polynomial x^31+x^28+1: shift left; new bit[0] = q[30]^q[27]; tx_bit = q[30].
REQ-016 SHALL have FSM states IDLE=0, SYNC=1, CHECK=2.
REQ-017 SHALL, on start in any state, load the generator seed 31'd1, clear err_cnt, the sync counter, the run counter and the window counters, deassert locked, and enter SYNC on the next edge.
REQ-018 SHALL, on stop in any state, enter IDLE and deassert locked; stop SHALL take priority over a simultaneous start.
REQ-019 SHALL hold the generator frozen in IDLE and advance it one bit per enabled cycle in SYNC and CHECK.
REQ-020 SHALL, in SYNC, shift rx_bit into a 31-bit checker register for 31 enabled cycles, then enter CHECK.
REQ-021 SHALL, if the checker register is all zeros at the end of SYNC, remain in SYNC and restart the 31-cycle count.
REQ-022 SHALL, in CHECK, compute expected = chk[30]^chk[27], shift expected (not rx_bit) into chk, and flag an error when rx_bit != expected.
REQ-023 SHALL increment err_cnt one cycle after a flagged error, saturating at all-ones.
REQ-024 SHALL assert locked on the cycle after LOCK_BITS consecutive error-free CHECK bits; any error SHALL clear the run counter, and locked SHALL then stay high.
REQ-025 SHALL count errors per 32-bit CHECK window; on reaching LOSS_THR, it SHALL deassert locked, enter SYNC, and reset the window; err_cnt SHALL be preserved.
REQ-026 SHALL freeze all registers, including counters and FSM, while ena=0; start and stop SHALL be ignored while ena=0.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set state=IDLE, generator=31'd1 (tx_bit=0), chk=0, locked=0, err_cnt=0, and all counters to 0.
REQ-028 SHALL, on reset asserted mid-test, abandon the test; after release, the block SHALL wait in IDLE for start.

Configuration
REQ-029 SHALL, when PRBS_ERR_INJECT_EN is defined, invert tx_bit for exactly one cycle after an enabled inject pulse in SYNC or CHECK, with generator state unaffected.
REQ-030 SHALL, when PRBS_ERR_INJECT_EN is undefined, ignore inject entirely, generate no injection logic, and pass tx_bit as q[30].

Structure
REQ-031 SHALL take from package prbs_bert_pkg: the state typedef/encoding, SEED (31'd1), TAP_A=30, TAP_B=27, and WIN_LEN=32.
REQ-032 SHALL instantiate the generator LFSR as sub-module prbs31_lfsr (ports clk, rst_n, load, adv, q[30:0]).

Verification
REQ-033 SHALL cover: reset, start, rx_bit=tx_bit loopback -> state=1 for 31 cycles, then 2; locked=1 after 64 further cycles; err_cnt=0 after 2000 cycles.
REQ-034 SHALL cover: locked loopback with rx inverted for 1 cycle -> err_cnt=1 on the next cycle; locked stays 1.
REQ-035 SHALL cover: start with rx_bit held 0 -> state stays 1 indefinitely; locked=0; err_cnt=0.
REQ-036 SHALL cover: locked, then rx continuously inverted -> 4th error in the window returns state=1 and locked=0; err_cnt=4.
REQ-037 SHALL cover: start and stop in the same cycle -> state=0; rst_n pulsed mid-CHECK -> all outputs at reset values asynchronously.
REQ-038 SHALL cover: an inject pulse while locked -> with PRBS_ERR_INJECT_EN, err_cnt=1; without it, err_cnt=0.
